playerr_ctl: RTL

Frame-rate motion and combat controller for the right-hand player. Samples the player-R buttons and the opponent-hit flag once per video frame. Produces the position/pose bus consumed by the playerR draw stage: RP_x_pos, RP_y_pos, sword_pos, x_sword_pos, change_legs and dead_R. All state advances only on the frame tick, which is derived internally from vsync.

---
 rtl/playerr_if.sv | 30 +++
 rtl/playerr_ctl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/playerr_if.sv
// Player-R control bus: button/hit inputs from the input stage and the
// position/pose outputs read by the playerR draw stage.
interface playerr_if;
   logic        btn_left;
   logic        btn_right;
   logic        btn_jump;
   logic        btn_thrust;
   logic        btn_sword_up;
   logic        btn_sword_down;
   logic        hit_R;

   logic [11:0] RP_x_pos;
   logic [11:0] RP_y_pos;
   logic [4:0]  sword_pos;
   logic [11:0] x_sword_pos;
   logic        change_legs;
   logic        dead_R;

   modport master (
      output btn_left, btn_right, btn_jump, btn_thrust,
             btn_sword_up, btn_sword_down, hit_R,
      input  RP_x_pos, RP_y_pos, sword_pos, x_sword_pos, change_legs, dead_R
   );

   modport slave (
      input  btn_left, btn_right, btn_jump, btn_thrust,
             btn_sword_up, btn_sword_down, hit_R,
      output RP_x_pos, RP_y_pos, sword_pos, x_sword_pos, change_legs, dead_R
   );
endinterface

// File: rtl/playerr_ctl.sv
// Frame-rate motion and combat controller for player R. All state advances
// once per video frame, on the tick derived from the rising edge of vsync.
module playerr_ctl #(
   parameter int unsigned STEP        = 4,
   parameter int unsigned RP_X_MAX    = 845,
   parameter int unsigned JUMP_STEP   = 4,
   parameter int unsigned JUMP_HEIGHT = 64,
   parameter int unsigned THRUST_STEP = 4,
   parameter int unsigned THRUST_MAX  = 16,
   parameter int unsigned SWORD_STEP  = 8,
   parameter int unsigned SWORD_MAX   = 24,
   parameter int unsigned LEG_PERIOD  = 8,
   parameter int unsigned DEAD_FRAMES = 120
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      vsync_in,
   playerr_if.slave  bus
);

   localparam int unsigned LEG_W  = (LEG_PERIOD  > 1) ? $clog2(LEG_PERIOD)  : 1;
   localparam int unsigned DEAD_W = (DEAD_FRAMES > 1) ? $clog2(DEAD_FRAMES) : 1;

   localparam logic [11:0]       STEP_V    = 12'(STEP);
   localparam logic [11:0]       X_MAX_V   = 12'(RP_X_MAX);
   localparam logic [11:0]       JSTEP_V   = 12'(JUMP_STEP);
   localparam logic [11:0]       JHEIGHT_V = 12'(JUMP_HEIGHT);
   localparam logic [11:0]       TSTEP_V   = 12'(THRUST_STEP);
   localparam logic [11:0]       TMAX_V    = 12'(THRUST_MAX);
   localparam logic [4:0]        SSTEP_V   = 5'(SWORD_STEP);
   localparam logic [4:0]        SMAX_V    = 5'(SWORD_MAX);
   localparam logic [LEG_W-1:0]  LEG_LAST  = LEG_W'(LEG_PERIOD - 1);
   localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_FRAMES - 1);

   typedef enum logic [2:0] {
      IDLE,
      WALK,
      JUMP_UP,
      JUMP_DOWN,
      THRUST_OUT,
      THRUST_BACK,
      DEAD
   } state_t;

   // IDLE must stay the all-zero encoding so that clearing the record resets the FSM.
   typedef struct packed {
      state_t             state;
      logic [11:0]        x;
      logic [11:0]        y;
      logic [4:0]         sw;
      logic [11:0]        xs;
      logic               legs;
      logic [LEG_W-1:0]   leg_cnt;
      logic [DEAD_W-1:0]  dead_cnt;
      logic               hit_pend;
      logic               up_hist;
      logic               dn_hist;
   } regs_t;

   regs_t       r_q;
   regs_t       r_d;
   logic        vsync_q;
   logic        tick;
   logic [11:0] x_move;
   logic        up_edge;
   logic        dn_edge;

   assign tick = vsync_in & ~vsync_q;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q <= 1'b0;
         r_q     <= '0;
      end else begin
         vsync_q <= vsync_in;
         r_q     <= r_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      r_d     = r_q;
      x_move  = r_q.x;
      up_edge = bus.btn_sword_up   & ~r_q.up_hist;
      dn_edge = bus.btn_sword_down & ~r_q.dn_hist;

      if (bus.btn_left && !bus.btn_right) begin
         x_move = (r_q.x > X_MAX_V - STEP_V) ? X_MAX_V : r_q.x + STEP_V;
      end else if (bus.btn_right && !bus.btn_left) begin
         x_move = (r_q.x < STEP_V) ? 12'd0 : r_q.x - STEP_V;
      end

      // A hit is remembered between frames and acted on at the next tick.
      r_d.hit_pend = r_q.hit_pend | (bus.hit_R & (r_q.state != DEAD));

      if (tick) begin
         r_d.up_hist = bus.btn_sword_up;
         r_d.dn_hist = bus.btn_sword_down;

         if (r_q.state != DEAD && (r_q.hit_pend || bus.hit_R)) begin
            r_d.state    = DEAD;
            r_d.hit_pend = 1'b0;
            r_d.dead_cnt = '0;
         end else begin
            case (r_q.state)
               IDLE, WALK: begin
                  r_d.x = x_move;
                  if (up_edge && !dn_edge) begin
                     r_d.sw = (r_q.sw > SMAX_V - SSTEP_V) ? SMAX_V : r_q.sw + SSTEP_V;
                  end else if (dn_edge && !up_edge) begin
                     r_d.sw = (r_q.sw < SSTEP_V) ? 5'd0 : r_q.sw - SSTEP_V;
                  end
                  if (bus.btn_jump)         r_d.state = JUMP_UP;
                  else if (bus.btn_thrust)  r_d.state = THRUST_OUT;
                  else if (x_move != r_q.x) r_d.state = WALK;
                  else                      r_d.state = IDLE;
               end
               JUMP_UP: begin
                  r_d.x = x_move;
                  r_d.y = r_q.y + JSTEP_V;
                  if (r_d.y == JHEIGHT_V) r_d.state = JUMP_DOWN;
               end
               JUMP_DOWN: begin
                  r_d.x = x_move;
                  r_d.y = r_q.y - JSTEP_V;
                  if (r_d.y == 12'd0) r_d.state = IDLE;
               end
               THRUST_OUT: begin
                  r_d.xs = r_q.xs + TSTEP_V;
                  if (r_d.xs == TMAX_V) r_d.state = THRUST_BACK;
               end
               THRUST_BACK: begin
                  r_d.xs = r_q.xs - TSTEP_V;
                  if (r_d.xs == 12'd0) r_d.state = IDLE;
               end
               DEAD: begin
                  if (r_q.dead_cnt == DEAD_LAST) begin
                     r_d.state    = IDLE;
                     r_d.dead_cnt = '0;
                     r_d.x        = '0;
                     r_d.y        = '0;
                     r_d.sw       = '0;
                     r_d.xs       = '0;
                  end else begin
                     r_d.dead_cnt = r_q.dead_cnt + DEAD_W'(1);
                  end
               end
               default: r_d.state = IDLE;
            endcase
         end

         // Leg animation runs only while the frame ends in WALK.
         if (r_d.state == WALK) begin
            if (r_q.leg_cnt == LEG_LAST) begin
               r_d.leg_cnt = '0;
               r_d.legs    = ~r_q.legs;
            end else begin
               r_d.leg_cnt = r_q.leg_cnt + LEG_W'(1);
            end
         end else begin
            r_d.leg_cnt = '0;
            r_d.legs    = 1'b0;
         end
      end
   end

   assign bus.RP_x_pos    = r_q.x;
   assign bus.RP_y_pos    = r_q.y;
   assign bus.sword_pos   = r_q.sw;
   assign bus.x_sword_pos = r_q.xs;
   assign bus.change_legs = r_q.legs;
   assign bus.dead_R      = (r_q.state == DEAD);

endmodule
